reg_bank_fwd: RTL and testbench
===============================

Name: reg_bank_fwd

Overview:
Parametrised register bank with an internal forwarding unit, the next generation of the operand-fetch stage. Reads two source registers per instruction and registers them into the execute stage. Tracks destination tags of the three in-flight instructions (EX, DM, WB) and generates operand-forwarding selects itself, so no external mux-select logic is needed. Also supports pipeline stall and immediate substitution on operand B.

Parameters:
DATA_W, 8, operand / register width in bits
ADDR_W, 5, register address width
DEPTH, 32, number of registers; legal range 2 to 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  1 = hold operand registers and tag pipeline
rs_a  in  ADDR_W  source A address of the decoding instruction
rs_b  in  ADDR_W  source B address of the decoding instruction
rd  in  ADDR_W  destination address of the decoding instruction
rd_vld  in  1  decoding instruction writes rd
wr_en  in  1  register-bank write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
ans_ex  in  DATA_W  result of the instruction tagged EX
ans_dm  in  DATA_W  result of the instruction tagged DM
ans_wb  in  DATA_W  result of the instruction tagged WB
imm  in  DATA_W  immediate value
imm_sel  in  1  1 = B output is imm
A  out  DATA_W  operand A to execute
B  out  DATA_W  operand B to execute
fwd_sel_a  out  2  A source: 00 reg, 01 ex, 10 dm, 11 wb
fwd_sel_b  out  2  B source, same encoding as fwd_sel_a

Behaviour:
- Reset (reset=0, asynchronous):
  - bank[i] <= i mod 2**DATA_W.
  - Operand registers op_a/op_b <= 0; latched addresses <= 0.
  - All tags invalid.
  - Result: A=0, fwd_sel_a=00, fwd_sel_b=00; B=0 when imm_sel=0.
- Write port: on every rising edge with wr_en=1 and wr_addr<DEPTH, bank[wr_addr] <= wr_data. The write is independent of stall. wr_addr>=DEPTH is ignored.
- Read, stall=0: on the edge, op_a <= bank[rs_a] and op_b <= bank[rs_b], with write-through: if wr_en and wr_addr==rs_x, capture wr_data. rs_a/rs_b are latched as src_a/src_b. An address >=DEPTH reads 0.
- Tag pipeline, stall=0, one shift per edge, each tag = {valid, addr}:
  - tag_cur <= {rd_vld, rd}
  - tag_ex <= tag_cur
  - tag_dm <= tag_ex
  - tag_wb <= tag_dm
- tag_cur belongs to the instruction currently at A/B. ans_ex/ans_dm/ans_wb belong to tag_ex/tag_dm/tag_wb respectively.
- Stall=1: op_x, src_x and all tags hold. Write snoop: if wr_en and wr_addr==src_x, op_x <= wr_data, so held operands never go stale.
- Forwarding (combinational from registered state), per operand x, first match wins:
  1. tag_ex valid and addr==src_x -> 01 (ans_ex)
  2. tag_dm match -> 10 (ans_dm)
  3. tag_wb match -> 11 (ans_wb)
  4. otherwise 00 (op_x)
- A = the source selected by fwd_sel_a. B = imm when imm_sel=1, else the source selected by fwd_sel_b. fwd_sel_b reports the forwarding decision regardless of imm_sel.
- Latency: rs to A/B is 1 clock; stall extends it by the stall length.
- Reset asserted mid-operation: everything returns to reset values immediately. Forwarding stays disabled until new tags shift in.

Optional Feature:
ZERO_REG_EN:
- Defined: register 0 always reads 0; writes to address 0 are dropped; write-through and snoop to address 0 are suppressed; tags with addr 0 never match, so fwd_sel is 00 for src 0.
- Undefined: register 0 is an ordinary register, reset to 0, writable and forwardable.

Test Plan:
- Reset, then rs_a=3, rs_b=10, imm_sel=0, one edge -> A=0x03, B=0x0A, fwd_sel_a=fwd_sel_b=00.
- Issue rd=5 rd_vld=1, next instruction rs_a=5, ans_ex=0x77 -> A=0x77, fwd_sel_a=01. Two edges later with the same src, ans_wb=0x77 -> fwd_sel_a=11.
- Tags EX and DM both rd=7, rs_b=7, ans_ex=0x11, ans_dm=0x22 -> B=0x11, fwd_sel_b=01 (priority check).
- wr_en=1, wr_addr=9, wr_data=0xA5 on the same edge that reads rs_a=9 -> A=0xA5 (write-through).
- stall=1 for 3 cycles holding src_a=4 with a write of 0x3C to r4 during the stall -> A=0x3C while stalled; tags unchanged; after release the pipeline resumes.
- With ZERO_REG_EN: write 0xFF to r0, read rs_a=0 with tag_ex addr 0 valid -> A=0x00, fwd_sel_a=00. Without the macro: A=ans_ex, fwd_sel_a=01.

Source files
------------

// File: rtl/reg_bank_fwd.sv
// Operand-fetch register bank with built-in EX/DM/WB forwarding unit.
// Optional ZERO_REG_EN: hard-wired zero register at address 0.
module reg_bank_fwd #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rd_vld,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
  } tag_t;

`ifdef ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] bank_q [DEPTH];
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [DATA_W-1:0] op_a_d, op_b_d;
  logic [ADDR_W-1:0] src_a_q, src_b_q;
  tag_t              tag_cur_q, tag_ex_q;
  tag_t              tag_dm_q, tag_wb_q;
  logic              wr_ok;

  function automatic logic in_rng(
    input logic [ADDR_W-1:0] ad
  );
    return ({1'b0, ad} < DEPTH_L);
  endfunction

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] ad
  );
    return ZERO && (ad == '0);
  endfunction

  function automatic logic hit(
    input tag_t              t,
    input logic [ADDR_W-1:0] src
  );
    return t.vld && (t.addr == src)
      && !is_zero(src);
  endfunction

  function automatic logic [1:0] fsel(
    input tag_t              ex,
    input tag_t              dm,
    input tag_t              wb,
    input logic [ADDR_W-1:0] src
  );
    logic [1:0] s;
    s = 2'b00;
    if (hit(ex, src))      s = 2'b01;
    else if (hit(dm, src)) s = 2'b10;
    else if (hit(wb, src)) s = 2'b11;
    return s;
  endfunction

  always_comb begin
    wr_ok = wr_en && in_rng(wr_addr)
      && !is_zero(wr_addr);
  end

  // Read ports with write-through of a same-edge bank write
  always_comb begin
    op_a_d = '0;
    if (in_rng(rs_a) && !is_zero(rs_a)) begin
      if (wr_ok && (wr_addr == rs_a))
        op_a_d = wr_data;
      else
        op_a_d = bank_q[rs_a];
    end
  end

  always_comb begin
    op_b_d = '0;
    if (in_rng(rs_b) && !is_zero(rs_b)) begin
      if (wr_ok && (wr_addr == rs_b))
        op_b_d = wr_data;
      else
        op_b_d = bank_q[rs_b];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        bank_q[i] <= DATA_W'(i);
    end else if (wr_ok) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      tag_cur_q <= '0;
      tag_ex_q  <= '0;
      tag_dm_q  <= '0;
      tag_wb_q  <= '0;
    end else if (!stall) begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      src_a_q   <= rs_a;
      src_b_q   <= rs_b;
      tag_cur_q <= '{vld: rd_vld, addr: rd};
      tag_ex_q  <= tag_cur_q;
      tag_dm_q  <= tag_ex_q;
      tag_wb_q  <= tag_dm_q;
    end else begin
      // Held operands snoop the write port so they never go stale
      if (wr_ok && (wr_addr == src_a_q))
        op_a_q <= wr_data;
      if (wr_ok && (wr_addr == src_b_q))
        op_b_q <= wr_data;
    end
  end

  always_comb begin
    fwd_sel_a = fsel(tag_ex_q, tag_dm_q,
                     tag_wb_q, src_a_q);
    fwd_sel_b = fsel(tag_ex_q, tag_dm_q,
                     tag_wb_q, src_b_q);
  end

  always_comb begin
    unique case (fwd_sel_a)
      2'b01:   A = ans_ex;
      2'b10:   A = ans_dm;
      2'b11:   A = ans_wb;
      default: A = op_a_q;
    endcase
  end

  always_comb begin
    unique case (fwd_sel_b)
      2'b01:   B = ans_ex;
      2'b10:   B = ans_dm;
      2'b11:   B = ans_wb;
      default: B = op_b_q;
    endcase
    if (imm_sel) B = imm;
  end

endmodule

// File: tb/tb_reg_bank_fwd.sv
// Directed testbench for reg_bank_fwd (default parameters).
// Build with +define+ZERO_REG_EN to cover the zero-register variant.
module tb_reg_bank_fwd;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [4:0] rs_a, rs_b, rd;
  logic       rd_vld;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] ans_ex, ans_dm, ans_wb;
  logic [7:0] imm;
  logic       imm_sel;
  logic [7:0] a_o, b_o;
  logic [1:0] sel_a, sel_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_bank_fwd #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(32)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
    .rd_vld(rd_vld), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .ans_ex(ans_ex), .ans_dm(ans_dm),
    .ans_wb(ans_wb), .imm(imm),
    .imm_sel(imm_sel), .A(a_o), .B(b_o),
    .fwd_sel_a(sel_a), .fwd_sel_b(sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; rs_a = 0; rs_b = 0;
    rd = 0; rd_vld = 0; wr_en = 0;
    wr_addr = 0; wr_data = 0;
    ans_ex = 8'hE1; ans_dm = 8'hD1;
    ans_wb = 8'hB1; imm = 8'h00;
    imm_sel = 0;
  endtask

  task automatic flush();
    rd_vld = 0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    #13;
    total_cnt++;
    if (a_o !== 8'h00)
      $display("FAIL reset_A got %h want 00", a_o);
    else pass_cnt++;
    total_cnt++;
    if (b_o !== 8'h00)
      $display("FAIL reset_B got %h want 00", b_o);
    else pass_cnt++;
    total_cnt++;
    if ({sel_a, sel_b} !== 4'b0000)
      $display("FAIL reset_sel got %b want 0000",
               {sel_a, sel_b});
    else pass_cnt++;
    reset = 1;
    tick();
  endtask

  task automatic test_read();
    rs_a = 3; rs_b = 10;
    tick();
    total_cnt++;
    if (a_o !== 8'h03)
      $display("FAIL read_A got %h want 03", a_o);
    else pass_cnt++;
    total_cnt++;
    if (b_o !== 8'h0A)
      $display("FAIL read_B got %h want 0a", b_o);
    else pass_cnt++;
    total_cnt++;
    if ({sel_a, sel_b} !== 4'b0000)
      $display("FAIL read_sel got %b want 0000",
               {sel_a, sel_b});
    else pass_cnt++;
  endtask

  task automatic test_fwd_stages();
    rd = 5; rd_vld = 1; rs_a = 3;
    tick();
    rs_a = 5; rd_vld = 0;
    tick();
    ans_ex = 8'h77; #1;
    total_cnt++;
    if (a_o !== 8'h77 || sel_a !== 2'b01)
      $display("FAIL fwd_ex got %h/%b want 77/01",
               a_o, sel_a);
    else pass_cnt++;
    tick();
    ans_dm = 8'h66; #1;
    total_cnt++;
    if (a_o !== 8'h66 || sel_a !== 2'b10)
      $display("FAIL fwd_dm got %h/%b want 66/10",
               a_o, sel_a);
    else pass_cnt++;
    tick();
    ans_wb = 8'h77; #1;
    total_cnt++;
    if (a_o !== 8'h77 || sel_a !== 2'b11)
      $display("FAIL fwd_wb got %h/%b want 77/11",
               a_o, sel_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_o !== 8'h05 || sel_a !== 2'b00)
      $display("FAIL fwd_drain got %h/%b want 05/00",
               a_o, sel_a);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_priority();
    rd = 7; rd_vld = 1;
    tick();
    tick();
    rd_vld = 0; rs_a = 1; rs_b = 7;
    tick();
    ans_ex = 8'h11; ans_dm = 8'h22;
    ans_wb = 8'h33; #1;
    total_cnt++;
    if (b_o !== 8'h11 || sel_b !== 2'b01)
      $display("FAIL prio_ex got %h/%b want 11/01",
               b_o, sel_b);
    else pass_cnt++;
    total_cnt++;
    if (a_o !== 8'h01 || sel_a !== 2'b00)
      $display("FAIL prio_a got %h/%b want 01/00",
               a_o, sel_a);
    else pass_cnt++;
    imm_sel = 1; imm = 8'h5A; #1;
    total_cnt++;
    if (b_o !== 8'h5A || sel_b !== 2'b01)
      $display("FAIL imm_b got %h/%b want 5a/01",
               b_o, sel_b);
    else pass_cnt++;
    imm_sel = 0;
    tick();
    total_cnt++;
    if (b_o !== 8'h22 || sel_b !== 2'b10)
      $display("FAIL prio_dm got %h/%b want 22/10",
               b_o, sel_b);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_write_through();
    rs_a = 9; rs_b = 2;
    wr_en = 1; wr_addr = 9; wr_data = 8'hA5;
    tick();
    wr_en = 0;
    total_cnt++;
    if (a_o !== 8'hA5 || sel_a !== 2'b00)
      $display("FAIL wthru_A got %h/%b want a5/00",
               a_o, sel_a);
    else pass_cnt++;
    total_cnt++;
    if (b_o !== 8'h02)
      $display("FAIL wthru_B got %h want 02", b_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_o !== 8'hA5)
      $display("FAIL bank_wr got %h want a5", a_o);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    rd = 6; rd_vld = 1; rs_a = 1;
    tick();
    rd_vld = 0; rs_a = 4; rs_b = 6;
    tick();
    ans_ex = 8'h99; ans_dm = 8'h98; #1;
    total_cnt++;
    if (a_o !== 8'h04 || b_o !== 8'h99)
      $display("FAIL stall_pre got %h/%h want 04/99",
               a_o, b_o);
    else pass_cnt++;
    stall = 1; rs_a = 12; rs_b = 13;
    wr_en = 1; wr_addr = 4; wr_data = 8'h3C;
    tick();
    wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (a_o !== 8'h3C || sel_a !== 2'b00
          || sel_b !== 2'b01)
        $display("FAIL stall_hold%0d got %h/%b/%b want 3c/00/01",
                 i, a_o, sel_a, sel_b);
      else pass_cnt++;
      if (i < 2) tick();
    end
    stall = 0; rs_b = 6;
    tick();
    total_cnt++;
    if (a_o !== 8'h0C || sel_b !== 2'b10
        || b_o !== 8'h98)
      $display("FAIL stall_rel got %h/%b/%h want 0c/10/98",
               a_o, sel_b, b_o);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_zero_reg();
    wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
    rd = 0; rd_vld = 1; rs_a = 1;
    tick();
    wr_en = 0; rd_vld = 0; rs_a = 0;
    tick();
    ans_ex = 8'h44; #1;
`ifdef ZERO_REG_EN
    total_cnt++;
    if (a_o !== 8'h00 || sel_a !== 2'b00)
      $display("FAIL zero_fwd got %h/%b want 00/00",
               a_o, sel_a);
    else pass_cnt++;
    flush();
    total_cnt++;
    if (a_o !== 8'h00)
      $display("FAIL zero_rd got %h want 00", a_o);
    else pass_cnt++;
`else
    total_cnt++;
    if (a_o !== 8'h44 || sel_a !== 2'b01)
      $display("FAIL r0_fwd got %h/%b want 44/01",
               a_o, sel_a);
    else pass_cnt++;
    flush();
    total_cnt++;
    if (a_o !== 8'hFF)
      $display("FAIL r0_rd got %h want ff", a_o);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    rd = 9; rd_vld = 1; rs_a = 1;
    tick();
    rd_vld = 0; rs_a = 9; rs_b = 4;
    tick();
    ans_ex = 8'h5E; #1;
    total_cnt++;
    if (sel_a !== 2'b01 || a_o !== 8'h5E)
      $display("FAIL mid_pre got %h/%b want 5e/01",
               a_o, sel_a);
    else pass_cnt++;
    reset = 0; #1;
    total_cnt++;
    if (a_o !== 8'h00 || b_o !== 8'h00
        || {sel_a, sel_b} !== 4'b0000)
      $display("FAIL mid_rst got %h/%h/%b want 00/00/0000",
               a_o, b_o, {sel_a, sel_b});
    else pass_cnt++;
    #3 reset = 1;
    tick();
    total_cnt++;
    if (a_o !== 8'h09 || sel_a !== 2'b00)
      $display("FAIL mid_post got %h/%b want 09/00",
               a_o, sel_a);
    else pass_cnt++;
    total_cnt++;
    if (b_o !== 8'h04)
      $display("FAIL mid_bank got %h want 04", b_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_fwd_stages();
    test_priority();
    test_write_through();
    test_stall();
    test_zero_reg();
    test_reset_mid();
    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
